// File: rtl/pipe_control.sv
// Hazard and run-state controller for the five-stage Y86-64 pipeline.
// Drives stage stall/bubble controls, sequences IDLE/RUN/DRAIN/DONE and keeps saturating counters.
module pipe_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       M_icode,
  input  logic [3:0]       W_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic [1:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [3:0] S_AOK    = 4'b1000;
  localparam logic [3:0] S_HLT    = 4'b0100;
  localparam logic [3:0] S_ADR    = 4'b0010;
  localparam logic [3:0] S_INS    = 4'b0001;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  state_e           state_q, state_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cyc_q, cyc_d, ret_q, ret_d, stl_q, stl_d, bub_q, bub_d;

  logic lu, rt, mp, exc_m, exc_w, active, in_run;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    lu     = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
             ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    rt     = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    mp     = (E_icode == I_JXX) && !e_Cnd;
    exc_m  = is_exc(m_stat);
    exc_w  = is_exc(W_stat);
    active = (state_q == RUN) || (state_q == DRAIN);
    in_run = (state_q == RUN);
  end

  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    case (state_q)
      IDLE: begin
        F_stall  = 1'b1;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
      end
      RUN, DRAIN: begin
        F_stall  = lu | rt;
        D_bubble = mp | (rt & ~lu);
        // A bubble into D overrides any hold of D
        D_stall  = lu & ~(mp | (rt & ~lu));
        E_bubble = mp | lu;
        M_bubble = (state_q == DRAIN) | exc_m | exc_w;
        W_stall  = exc_w;
      end
      DONE: begin
        F_stall = 1'b1;
        D_stall = 1'b1;
        W_stall = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    err_d    = err_q;
    case (state_q)
      IDLE:  if (start) state_d = RUN;
      RUN, DRAIN: begin
        if (exc_w) begin
          state_d  = DONE;
          halted_d = (W_stat == S_HLT);
          err_d    = (W_stat == S_ADR) || (W_stat == S_INS);
        end else if (in_run && exc_m) begin
          state_d = DRAIN;
        end
      end
      DONE:  state_d = DONE;
    endcase
    cyc_d = sat_inc(cyc_q, active);
    ret_d = sat_inc(ret_q, active && (W_stat == S_AOK) && (W_icode != I_NOP));
    stl_d = sat_inc(stl_q, in_run && F_stall);
    bub_d = sat_inc(bub_q, in_run && (D_bubble || E_bubble));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      cyc_q    <= '0;
      ret_q    <= '0;
      stl_q    <= '0;
      bub_q    <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
      err_q    <= err_d;
      cyc_q    <= cyc_d;
      ret_q    <= ret_d;
      stl_q    <= stl_d;
      bub_q    <= bub_d;
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
  assign stall_cnt   = stl_q;
  assign bubble_cnt  = bub_q;

endmodule
